// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, opcode encodings and the request bundle.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int OP_W    = 5;
   localparam int SHAMT_W = 5;

   localparam logic [OP_W-1:0] ALU_ADD = 5'b00000;
   localparam logic [OP_W-1:0] ALU_SUB = 5'b00001;
   localparam logic [OP_W-1:0] ALU_AND = 5'b00010;
   localparam logic [OP_W-1:0] ALU_OR  = 5'b00011;
   localparam logic [OP_W-1:0] ALU_SLL = 5'b00100;
   localparam logic [OP_W-1:0] ALU_SRA = 5'b00101;

   typedef struct packed {
      logic [OP_W-1:0]    opcode;
      logic [SHAMT_W-1:0] shamt;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Flags always reflect a vs b (signed); ovf is the
// add overflow for ADD and the subtract overflow for every other opcode.
module alu
   import alu_pkg::*;
(
   input  logic [4:0]  i_opcode,
   input  logic [4:0]  i_shamt,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_result,
   output logic        o_ne,
   output logic        o_lt,
   output logic        o_ovf
);

   logic [31:0] w_sum;
   logic [31:0] w_diff;
   logic        w_add_ovf;
   logic        w_sub_ovf;

   assign w_sum     = i_a + i_b;
   assign w_diff    = i_a - i_b;
   assign w_add_ovf = (i_a[31] == i_b[31]) & (w_sum[31] != i_a[31]);
   assign w_sub_ovf = (i_a[31] != i_b[31]) & (w_diff[31] != i_a[31]);

   assign o_ne  = (i_a != i_b);
   assign o_lt  = ($signed(i_a) < $signed(i_b));
   assign o_ovf = (i_opcode == ALU_ADD) ? w_add_ovf : w_sub_ovf;

   always_comb begin
      o_result = '0;
      case (i_opcode)
         ALU_ADD: o_result = w_sum;
         ALU_SUB: o_result = w_diff;
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_SLL: o_result = i_a << i_shamt;
         ALU_SRA: o_result = $signed(i_a) >>> i_shamt;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties (ARB_MODE=1) or fixed priority to port 0.
// The last-grant register only moves when a grant is actually taken (i_en).
module rr_arb2 #(
   parameter int ARB_MODE = 1
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_en,
   output logic o_gnt_valid,
   output logic o_gnt_id
);

   logic w_tie;

   assign w_tie       = i_valid0 & i_valid1;
   assign o_gnt_valid = i_valid0 | i_valid1;

   generate
      if (ARB_MODE == 1) begin : g_rr
         logic r_last;

         assign o_gnt_id = w_tie ? ~r_last : ~i_valid0;

         // Starts at 1 so that port 0 wins the first tie after reset.
         always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_last <= 1'b1;
            end else if (i_en) begin
               r_last <= o_gnt_id;
            end
         end
      end else begin : g_fixed
         assign o_gnt_id = w_tie ? 1'b0 : ~i_valid0;
      end
   endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU through a 2-stage pipeline (operand register,
// result register) with result backpressure and id-tagged responses.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int ARB_MODE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_opcode,
   input  logic [4:0]  req0_shamt,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_opcode,
   input  logic [4:0]  req1_shamt,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_result,
   output logic        resp_ne,
   output logic        resp_lt,
   output logic        resp_ovf
);

   logic        w_stall;
   logic        w_accept;
   logic        w_xfer;
   logic        w_gnt_valid;
   logic        w_gnt_id;
   alu_req_t    w_gnt_req;
   logic [31:0] w_alu_result;
   logic        w_alu_ne;
   logic        w_alu_lt;
   logic        w_alu_ovf;

   logic        r_s1_valid;
   logic        r_s1_id;
   alu_req_t    r_s1_req;
   logic        r_s2_valid;
   logic        r_s2_id;
   logic [31:0] r_s2_result;
   logic        r_s2_ne;
   logic        r_s2_lt;
   logic        r_s2_ovf;

   // Readies are gated by reset as well so nothing is offered while held in reset.
   assign w_stall  = r_s2_valid & ~resp_ready;
   assign w_accept = reset & ~w_stall;
   assign w_xfer   = w_accept & w_gnt_valid;

   assign req0_ready = w_xfer & ~w_gnt_id;
   assign req1_ready = w_xfer &  w_gnt_id;

   assign w_gnt_req = w_gnt_id ? {req1_opcode, req1_shamt, req1_a, req1_b}
                               : {req0_opcode, req0_shamt, req0_a, req0_b};

   rr_arb2 #(
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .i_clock     (clock),
      .i_reset_n   (reset),
      .i_valid0    (req0_valid),
      .i_valid1    (req1_valid),
      .i_en        (w_xfer),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_id    <= 1'b0;
         r_s1_req   <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1_id  <= w_gnt_id;
            r_s1_req <= w_gnt_req;
         end
      end
   end

   alu u_alu (
      .i_opcode (r_s1_req.opcode),
      .i_shamt  (r_s1_req.shamt),
      .i_a      (r_s1_req.a),
      .i_b      (r_s1_req.b),
      .o_result (w_alu_result),
      .o_ne     (w_alu_ne),
      .o_lt     (w_alu_lt),
      .o_ovf    (w_alu_ovf)
   );

   // Loading while the consumer takes the current result keeps the pipe bubble-free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s2_valid  <= 1'b0;
         r_s2_id     <= 1'b0;
         r_s2_result <= '0;
         r_s2_ne     <= 1'b0;
         r_s2_lt     <= 1'b0;
         r_s2_ovf    <= 1'b0;
      end else if (!w_stall) begin
         r_s2_valid  <= r_s1_valid;
         r_s2_id     <= r_s1_id;
         r_s2_result <= w_alu_result;
         r_s2_ne     <= w_alu_ne;
         r_s2_lt     <= w_alu_lt;
         r_s2_ovf    <= w_alu_ovf;
      end
   end

   assign resp_valid  = r_s2_valid;
   assign resp_id     = r_s2_id;
   assign resp_result = r_s2_result;
   assign resp_ne     = r_s2_ne;
   assign resp_lt     = r_s2_lt;
   assign resp_ovf    = r_s2_ovf;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: two DUTs (index 0 round-robin, index 1 fixed priority)
// checked against a transaction-level arithmetic model.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        rv   [2][2];
   logic [4:0]  rop  [2][2];
   logic [4:0]  rsh  [2][2];
   logic [31:0] ra   [2][2];
   logic [31:0] rb   [2][2];
   logic        rdy  [2][2];
   logic        rrdy [2];
   logic        rvld [2];
   logic        rid  [2];
   logic [31:0] rres [2];
   logic        rne  [2];
   logic        rlt  [2];
   logic        rovf [2];

   alu_share_arbiter #(.ARB_MODE(1)) dut_rr (
      .clock(clk), .reset(rst_n),
      .req0_valid(rv[0][0]), .req0_ready(rdy[0][0]), .req0_opcode(rop[0][0]),
      .req0_shamt(rsh[0][0]), .req0_a(ra[0][0]), .req0_b(rb[0][0]),
      .req1_valid(rv[0][1]), .req1_ready(rdy[0][1]), .req1_opcode(rop[0][1]),
      .req1_shamt(rsh[0][1]), .req1_a(ra[0][1]), .req1_b(rb[0][1]),
      .resp_valid(rvld[0]), .resp_ready(rrdy[0]), .resp_id(rid[0]),
      .resp_result(rres[0]), .resp_ne(rne[0]), .resp_lt(rlt[0]), .resp_ovf(rovf[0])
   );

   alu_share_arbiter #(.ARB_MODE(0)) dut_fp (
      .clock(clk), .reset(rst_n),
      .req0_valid(rv[1][0]), .req0_ready(rdy[1][0]), .req0_opcode(rop[1][0]),
      .req0_shamt(rsh[1][0]), .req0_a(ra[1][0]), .req0_b(rb[1][0]),
      .req1_valid(rv[1][1]), .req1_ready(rdy[1][1]), .req1_opcode(rop[1][1]),
      .req1_shamt(rsh[1][1]), .req1_a(ra[1][1]), .req1_b(rb[1][1]),
      .resp_valid(rvld[1]), .resp_ready(rrdy[1]), .resp_id(rid[1]),
      .resp_result(rres[1]), .resp_ne(rne[1]), .resp_lt(rlt[1]), .resp_ovf(rovf[1])
   );

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        ne;
      logic        lt;
      logic        ovf;
   } exp_t;

   exp_t sbq      [2][$];
   int   ids_seen [2][$];
   int   last_m   [2];
   int   n_pop    [2];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   r1_ready_cnt = 0;
   bit   rand_done = 1'b0;

   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;

   function automatic exp_t model(input int id, input logic [4:0] op, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, s;
      sa = $signed(a);
      sb = $signed(b);
      e.id  = id[0];
      e.ne  = (a != b);
      e.lt  = (sa < sb);
      s     = (op == ALU_ADD) ? sa + sb : sa - sb;
      e.ovf = (s > S_MAX) || (s < S_MIN);
      case (op)
         5'd0: s = sa + sb;
         5'd1: s = sa - sb;
         5'd2: s = longint'(a & b);
         5'd3: s = longint'(a | b);
         5'd4: s = longint'({32'b0, a}) * (longint'(1) << sh);
         5'd5: s = sa >>> sh;
         default: s = 0;
      endcase
      e.res = s[31:0];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: checks responses against the queue head and readies against the
   // arbitration rule, and records each accepted request as an expected response.
   always @(negedge clk) begin
      exp_t e;
      int   g;
      logic stall;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            last_m[d] = 1;
            chk("rst_resp_valid", rvld[d], 0);
         end else begin
            if (rvld[d]) begin
               if (sbq[d].size() == 0) begin
                  chk("unexpected_resp", 1, 0);
               end else begin
                  e = sbq[d][0];
                  chk("resp_id", rid[d], e.id);
                  chk("resp_result", rres[d], e.res);
                  chk("resp_ne", rne[d], e.ne);
                  chk("resp_lt", rlt[d], e.lt);
                  chk("resp_ovf", rovf[d], e.ovf);
                  if (rrdy[d]) begin
                     void'(sbq[d].pop_front());
                     ids_seen[d].push_back(int'(e.id));
                     n_pop[d]++;
                     $display("dut%0d resp id=%0d result=0x%08h ne=%0d lt=%0d ovf=%0d",
                              d, rid[d], rres[d], rne[d], rlt[d], rovf[d]);
                  end
               end
            end
            stall = rvld[d] & ~rrdy[d];
            g = -1;
            if (!stall) begin
               if (rv[d][0] && rv[d][1]) g = (d == 0) ? ((last_m[d] == 0) ? 1 : 0) : 0;
               else if (rv[d][0]) g = 0;
               else if (rv[d][1]) g = 1;
            end
            chk("req0_ready", rdy[d][0], g == 0);
            chk("req1_ready", rdy[d][1], g == 1);
            if (d == 1 && rdy[1][1]) r1_ready_cnt++;
            if (g >= 0) begin
               sbq[d].push_back(model(g, rop[d][g], rsh[d][g], ra[d][g], rb[d][g]));
               last_m[d] = g;
            end
         end
      end
   end

   task automatic set_req(input int d, input int p, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
      rv[d][p] = 1'b1; rop[d][p] = op; rsh[d][p] = sh; ra[d][p] = a; rb[d][p] = b;
   endtask

   task automatic drop(input int d, input int p);
      rv[d][p] = 1'b0;
   endtask

   task automatic wait_xfer(input int d, input int p);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rdy[d][p] && t < 200);
      if (!rdy[d][p]) chk("xfer_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic send(input int d, input int p, input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
      set_req(d, p, op, sh, a, b);
      wait_xfer(d, p);
   endtask

   task automatic wait_drain(input int d);
      int t = 0;
      while ((sbq[d].size() != 0 || rvld[d]) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_queue", sbq[d].size(), 0);
   endtask

   task automatic chk_reset_outs(input int d);
      chk("rst_valid", rvld[d], 0);
      chk("rst_id", rid[d], 0);
      chk("rst_result", rres[d], 0);
      chk("rst_ne", rne[d], 0);
      chk("rst_lt", rlt[d], 0);
      chk("rst_ovf", rovf[d], 0);
      chk("rst_ready0", rdy[d][0], 0);
      chk("rst_ready1", rdy[d][1], 0);
   endtask

   task automatic drive_rand(input int d, input int p);
      int idle;
      for (int i = 0; i < 20; i++) begin
         idle = $urandom_range(0, 2);
         if (idle > 0) begin
            drop(d, p);
            repeat (idle) begin @(posedge clk); #1; end
         end
         send(d, p, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      end
      drop(d, p);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap_res;
      logic        snap_id;
      int          pop_base;
      for (int d = 0; d < 2; d++) begin
         rrdy[d] = 1'b1; n_pop[d] = 0; last_m[d] = 1;
         for (int p = 0; p < 2; p++) begin
            rv[d][p] = 1'b0; rop[d][p] = '0; rsh[d][p] = '0; ra[d][p] = '0; rb[d][p] = '0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      rv[0][0] = 1'b1; rv[0][1] = 1'b1; rv[1][0] = 1'b1; rv[1][1] = 1'b1;
      #1;
      chk_reset_outs(0);
      chk_reset_outs(1);
      for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) rv[d][p] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // SUB on port 0 with fixed latency
      send(0, 0, ALU_SUB, 5'd0, 32'h11010010, 32'h00001100);
      drop(0, 0);
      chk("t1_not_yet_valid", rvld[0], 0);
      @(posedge clk); #1;
      chk("t1_valid", rvld[0], 1);
      chk("t1_id", rid[0], 0);
      chk("t1_result", rres[0], 32'h1100EF10);
      chk("t1_ne", rne[0], 1);
      chk("t1_lt", rlt[0], 0);
      wait_drain(0);

      // ADD overflow then SRA on port 1, back-to-back
      send(0, 1, ALU_ADD, 5'd0, 32'h40000000, 32'h40000000);
      send(0, 1, ALU_SRA, 5'd4, 32'hF0000000, 32'h0);
      drop(0, 1);
      chk("t2_add_result", rres[0], 32'h80000000);
      chk("t2_add_ovf", rovf[0], 1);
      chk("t2_add_id", rid[0], 1);
      @(posedge clk); #1;
      chk("t2_sra_result", rres[0], 32'hFF000000);
      chk("t2_sra_id", rid[0], 1);
      wait_drain(0);

      // Six cycles of contention in both arbitration modes
      for (int d = 0; d < 2; d++) begin
         ids_seen[d].delete();
         r1_ready_cnt = 0;
         set_req(d, 0, ALU_SLL, 5'd16, 32'h1, 32'h0);
         set_req(d, 1, ALU_SUB, 5'd0, 32'h80000001, 32'h7FFFFFFF);
         repeat (6) @(posedge clk);
         #1;
         drop(d, 0);
         drop(d, 1);
         wait_drain(d);
         chk("tie_count", ids_seen[d].size(), 6);
         for (int i = 0; i < ids_seen[d].size(); i++)
            chk(d == 0 ? "rr_id_seq" : "fp_id_seq", ids_seen[d][i], (d == 0) ? (i % 2) : 0);
         if (d == 1) chk("fp_req1_ready_count", r1_ready_cnt, 0);
      end

      // Backpressure: three ops, consumer stalls four cycles on the first result
      pop_base = n_pop[0];
      fork
         begin
            send(0, 0, ALU_ADD, 5'd0, 32'h00000001, 32'h00000002);
            send(0, 0, ALU_OR,  5'd0, 32'h0F0F0000, 32'h000000F0);
            send(0, 0, ALU_AND, 5'd0, 32'hFFFF00FF, 32'h12345678);
            drop(0, 0);
         end
         begin
            int t = 0;
            while (!rvld[0] && t < 50) begin @(posedge clk); #1; t++; end
            chk("bp_first_valid", rvld[0], 1);
            rrdy[0] = 1'b0;
            snap_res = rres[0];
            snap_id  = rid[0];
            repeat (4) begin
               @(negedge clk);
               chk("bp_hold_valid", rvld[0], 1);
               chk("bp_hold_result", rres[0], snap_res);
               chk("bp_hold_id", rid[0], snap_id);
               chk("bp_ready0_low", rdy[0][0], 0);
               chk("bp_ready1_low", rdy[0][1], 0);
            end
            @(posedge clk); #1;
            rrdy[0] = 1'b1;
         end
      join
      wait_drain(0);
      chk("bp_delivered", n_pop[0] - pop_base, 3);

      // Random traffic on both DUTs with random consumer backpressure
      fork
         begin
            fork
               drive_rand(0, 0);
               drive_rand(0, 1);
               drive_rand(1, 0);
               drive_rand(1, 1);
            join
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               rrdy[0] = ($urandom_range(0, 3) != 0);
               rrdy[1] = ($urandom_range(0, 3) != 0);
            end
            rrdy[0] = 1'b1;
            rrdy[1] = 1'b1;
         end
      join
      wait_drain(0);
      wait_drain(1);

      // Reset with both pipeline stages occupied
      send(0, 0, ALU_ADD, 5'd0, 32'h00000005, 32'h00000007);
      send(0, 0, ALU_SUB, 5'd0, 32'h00000009, 32'h00000003);
      chk("mid_s2_valid_before_reset", rvld[0], 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outs(0);
      drop(0, 0);
      sbq[0].delete();
      sbq[1].delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ids_seen[0].delete();
      set_req(0, 0, ALU_OR, 5'd0, 32'hA0000000, 32'h0000000A);
      set_req(0, 1, ALU_AND, 5'd0, 32'hFFFFFFFF, 32'h00FF00FF);
      @(negedge clk);
      chk("post_rst_tie_ready0", rdy[0][0], 1);
      chk("post_rst_tie_ready1", rdy[0][1], 0);
      @(posedge clk); #1;
      drop(0, 0);
      wait_xfer(0, 1);
      drop(0, 1);
      wait_drain(0);
      chk("post_rst_resp_count", ids_seen[0].size(), 2);
      if (ids_seen[0].size() > 0) chk("post_rst_first_id", ids_seen[0][0], 0);

      chk("final_queue0", sbq[0].size(), 0);
      chk("final_queue1", sbq[1].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
